pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/decode controller for the tri-state program counter (PC) and the shared address/data bus. Drives the PC's active-low Load and OE and active-high Enable, the memory read strobe and the instruction-register load. Sequences every instruction through fetch, decode and an optional jump, with a bounded wait for slow memory and a sticky fault on timeout.

## Interface
- FetchWaitMax, 15: maximum wait cycles tolerated in FETCH before FAULT (0 = memory must be ready on the first fetch cycle). Wait counter width is clog2(FetchWaitMax+1), minimum 1.
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  one clock; reset is synchronous and active-low. Shared with the PC.
- Start  in  1  level, active high: leaves IDLE or HALT. Ignored in every other state.
- MemReady  in  1  memory read data valid on the bus.
- IsHalt  in  1  decoded halt instruction; sampled in DECODE only.
- IsJump  in  1  decoded jump instruction; sampled in DECODE only.
- CondMet  in  1  jump condition true; sampled in DECODE only.
- PC_OE  out  1  active low: PC drives the bus.
- PC_Load  out  1  active low: PC loads D from the bus.
- PC_Enable  out  1  active high: PC increments.
- MemRd  out  1  active high memory read strobe.
- IR_Load  out  1  active high instruction-register load.
- Halted  out  1  high in HALT.
- Fault  out  1  high in FAULT.
- State  out  3  current state code.

## Operation
- States and codes:
  - IDLE=0
  - FETCH=1
  - DECODE=2
  - JUMP=3
  - HALT=4
  - FAULT=5
  - Codes 6–7 are unreachable and go to IDLE on the next clock.
- Reset (Reset=0 at posedge) forces IDLE and clears the wait counter. Overrides every state, including mid-fetch and FAULT.
- Reset/IDLE output values: PC_OE=1, PC_Load=1, PC_Enable=0, MemRd=0, IR_Load=0, Halted=0, Fault=0, State=0.
- IDLE: Start=1 → FETCH.
- FETCH:
  - PC_OE=0, MemRd=1.
  - MemReady=1: IR_Load=1 and PC_Enable=1 in the same cycle, then → DECODE.
  - MemReady=0 with counter < FetchWaitMax: counter+1, stay in FETCH.
  - MemReady=0 with counter == FetchWaitMax: → FAULT.
  - The counter clears on every entry to FETCH.
- DECODE: all outputs inactive. Next state by priority:
  - IsHalt → HALT.
  - Else IsJump & CondMet → JUMP.
  - Else → FETCH.
- JUMP: PC_Load=0 and PC_OE=1 (PC off the bus, so the operand source drives D), then → FETCH.
- HALT: Halted=1, other outputs inactive. Start=1 → FETCH, resuming at the current PC.
- FAULT: Fault=1, other outputs inactive. Only Reset exits.
- Invariants, every cycle:
  - PC_Load=0 and PC_Enable=1 are never asserted together (the PC gives Enable priority).
  - PC_OE=0 and PC_Load=0 are never asserted together.
  - MemRd=1 only in FETCH.
- Outputs are combinational decodes of the state register. IR_Load and PC_Enable additionally depend on MemReady in FETCH (Mealy). No other combinational input-to-output paths.

## Timing
- Sequential non-jump instruction: FETCH (1+w cycles, w = wait cycles) + DECODE (1 cycle) = 2+w cycles.
- Taken jump: 3+w cycles. Not-taken jump costs the same as a sequential instruction.
- PC increments at the posedge ending the accepting FETCH cycle, so the new PC value is visible during DECODE.
- Jump target is loaded at the posedge ending JUMP. The next FETCH presents the target.
- Timeout: FETCH cycles with index 0..FetchWaitMax may accept MemReady. MemReady low at index FetchWaitMax → State=5 on the next cycle, i.e. the (FetchWaitMax+2)-th cycle after FETCH entry.
- Start held high through HALT→FETCH→DECODE has no further effect; re-halting needs another halt instruction.
- Reset low during any cycle, including an accepting FETCH: the reset values apply at that posedge. No IR_Load or PC_Enable takes effect, because the PC is reset on the same edge.

## Test plan
- Reset low 2 cycles, then high with Start=0 → State=0, PC_OE=1, PC_Load=1, PC_Enable=0, MemRd=0, Fault=0 for 5 cycles.
- Start=1, MemReady tied 1, IsJump=IsHalt=0 → State alternates 1,2. One PC_Enable and one IR_Load pulse every 2 cycles. PC advances 0→1→2→3.
- MemReady delayed 3 cycles per fetch (FetchWaitMax=15) → FETCH lasts 4 cycles, MemRd held high throughout, exactly one PC_Enable per instruction.
- DECODE with IsJump=1, CondMet=1, target 0x40 on D → State 2→3→1, PC_Load=0 for one cycle, PC=0x40 at the next FETCH. With CondMet=0 → State 2→1 and PC unchanged by load.
- DECODE with IsHalt=1 and IsJump=1 → HALT (halt has priority), Halted=1. Start pulse → FETCH at the unchanged PC.
- MemReady held 0 with FetchWaitMax=3 → FAULT entered 5 cycles after FETCH entry, Fault=1 sticky against Start. Reset low → IDLE, Fault=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/decode controller for a tri-state program counter and the shared
// address/data bus, with bounded memory wait and a sticky timeout fault.
module pc_sequencer #(
    parameter int unsigned FetchWaitMax = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       MemReady,
    input  logic       IsHalt,
    input  logic       IsJump,
    input  logic       CondMet,
    output logic       PC_OE,
    output logic       PC_Load,
    output logic       PC_Enable,
    output logic       MemRd,
    output logic       IR_Load,
    output logic       Halted,
    output logic       Fault,
    output logic [2:0] State
);

    localparam int unsigned CntW = (FetchWaitMax == 0) ? 1 : $clog2(FetchWaitMax + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FetchWaitMax);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_JUMP   = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_next;

    // State and wait counter; reset wins over everything, including FAULT.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter only survives while waiting in FETCH, so every FETCH entry sees zero.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        PC_OE      = 1'b1;
        PC_Load    = 1'b1;
        PC_Enable  = 1'b0;
        MemRd      = 1'b0;
        IR_Load    = 1'b0;
        Halted     = 1'b0;
        Fault      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_FETCH;
            end
            S_FETCH: begin
                PC_OE = 1'b0;
                MemRd = 1'b1;
                if (MemReady) begin
                    IR_Load    = 1'b1;
                    PC_Enable  = 1'b1;
                    state_next = S_DECODE;
                end else if (cnt == CntMax) begin
                    state_next = S_FAULT;
                end else begin
                    cnt_next = cnt + CntW'(1);
                end
            end
            S_DECODE: begin
                if (IsHalt)                 state_next = S_HALT;
                else if (IsJump && CondMet) state_next = S_JUMP;
                else                        state_next = S_FETCH;
            end
            S_JUMP: begin
                // PC off the bus so the operand source can drive the target.
                PC_Load    = 1'b0;
                state_next = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
                if (Start) state_next = S_FETCH;
            end
            S_FAULT: begin
                Fault = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign State = 3'(state);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, multi-cycle corner sequences,
// and random instruction streams checked against an instruction-level model.
module tb_pc_sequencer;

    localparam int unsigned MAXW = 3;

    // Expected output vector: {State, PC_OE, PC_Load, PC_Enable, MemRd, IR_Load, Halted, Fault}
    localparam logic [9:0] E_IDLE  = {3'd0, 7'b1100000};
    localparam logic [9:0] E_DEC   = {3'd2, 7'b1100000};
    localparam logic [9:0] E_JUMP  = {3'd3, 7'b1000000};
    localparam logic [9:0] E_HALT  = {3'd4, 7'b1100010};
    localparam logic [9:0] E_FAULT = {3'd5, 7'b1100001};

    typedef struct {
        logic       rst;
        logic       st;
        logic       rdy;
        logic       h;
        logic       j;
        logic       c;
        logic [9:0] exp;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Reset, Start, MemReady, IsHalt, IsJump, CondMet;
    logic       PC_OE, PC_Load, PC_Enable, MemRd, IR_Load, Halted, Fault;
    logic [2:0] State;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pc     = 8'd0;
    logic [7:0] target = 8'd0;

    pc_sequencer #(.FetchWaitMax(MAXW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MemReady(MemReady),
        .IsHalt(IsHalt), .IsJump(IsJump), .CondMet(CondMet),
        .PC_OE(PC_OE), .PC_Load(PC_Load), .PC_Enable(PC_Enable), .MemRd(MemRd),
        .IR_Load(IR_Load), .Halted(Halted), .Fault(Fault), .State(State)
    );

    always #5 Clk = ~Clk;

    function automatic logic [9:0] ef(input logic acc);
        return acc ? {3'd1, 7'b0111100} : {3'd1, 7'b0101000};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic vec_t mk(input logic rst, st, rdy, h, j, c, input logic [9:0] e);
        vec_t v;
        v.rst = rst; v.st = st; v.rdy = rdy; v.h = h; v.j = j; v.c = c; v.exp = e;
        return v;
    endfunction

    // One clock: drive, check outputs and invariants mid-cycle, step the PC device model.
    task automatic cyc(input logic rst, st, rdy, h, j, c, input logic [9:0] exp, input string nm);
        logic [9:0] got;
        logic [7:0] pc_n;
        Reset = rst; Start = st; MemReady = rdy; IsHalt = h; IsJump = j; CondMet = c;
        #1;
        got = {State, PC_OE, PC_Load, PC_Enable, MemRd, IR_Load, Halted, Fault};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, exp);
        end
        total++;
        if ((!PC_Load && PC_Enable) || (!PC_OE && !PC_Load) || (MemRd && State != 3'd1)) begin
            bad++;
            $display("FAIL %s_invariant: got oe=%b ld=%b en=%b rd=%b st=%0d", nm,
                     PC_OE, PC_Load, PC_Enable, MemRd, State);
        end
        if (!rst)          pc_n = 8'd0;
        else if (PC_Enable) pc_n = pc + 8'd1;
        else if (!PC_Load)  pc_n = target;
        else                pc_n = pc;
        @(posedge Clk);
        pc = pc_n;
        #1;
    endtask

    task automatic check_pc(input logic [7:0] want, input string nm);
        total++;
        if (pc !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h want=%h", nm, pc, want);
        end
    endtask

    initial begin
        vec_t       tbl[$];
        logic [7:0] pc_exp;
        logic       h, j, c;
        int         kind;

        Reset = 1'b0; Start = 1'b0; MemReady = 1'b0;
        IsHalt = 1'b0; IsJump = 1'b0; CondMet = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Directed table: idle, sequential, taken/not-taken jump, halt priority/resume, reset
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, E_IDLE));
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, E_IDLE));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, E_IDLE));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, ef(0)));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, E_DEC));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, E_DEC));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, E_JUMP));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, E_DEC));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, ef(0)));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, E_DEC));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, E_HALT));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, E_HALT));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, E_DEC));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, ef(1)));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, E_DEC));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, E_HALT));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, E_HALT));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, E_IDLE));
        foreach (tbl[i])
            cyc(tbl[i].rst, tbl[i].st, tbl[i].rdy, tbl[i].h, tbl[i].j, tbl[i].c,
                tbl[i].exp, $sformatf("tbl%0d", i));

        // Longest tolerated wait: MemReady arrives at index MAXW
        cyc(1, 1, 0, 0, 0, 0, E_IDLE, "bw_idle");
        for (int i = 0; i < int'(MAXW); i++) cyc(1, 0, 0, 0, 0, 0, ef(0), "bw_wait");
        cyc(1, 0, 1, 0, 0, 0, ef(1), "bw_accept");
        cyc(1, 0, 0, 0, 0, 0, E_DEC, "bw_decode");
        cyc(1, 0, 0, 0, 0, 0, ef(0), "bw_refetch");
        cyc(0, 0, 0, 0, 0, 0, ef(0), "bw_rst");

        // Timeout: FAULT on the (MAXW+2)-th cycle after FETCH entry, sticky against Start
        cyc(1, 1, 0, 0, 0, 0, E_IDLE, "to_idle");
        for (int i = 0; i <= int'(MAXW); i++) cyc(1, 0, 0, 0, 0, 0, ef(0), "to_wait");
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 1, 1, 1, E_FAULT, "to_fault");
        cyc(0, 1, 0, 0, 0, 0, E_FAULT, "to_rst");
        cyc(1, 0, 0, 0, 0, 0, E_IDLE, "to_cleared");

        // Reset during an accepting FETCH wins over the DECODE transition
        cyc(1, 1, 0, 0, 0, 0, E_IDLE, "ra_idle");
        cyc(0, 0, 1, 0, 0, 0, ef(1), "ra_accept");
        cyc(1, 0, 1, 0, 0, 0, E_IDLE, "ra_idle_after");
        check_pc(8'd0, "ra_pc");

        // Random instruction stream against an instruction-level model
        pc_exp = 8'd0;
        cyc(0, 0, 0, 0, 0, 0, E_IDLE, "rnd_rst");
        cyc(1, 1, rb(), rb(), rb(), rb(), E_IDLE, "rnd_idle");
        for (int n = 0; n < 200; n++) begin
            bit timeout;
            int w;
            timeout = ($urandom_range(9, 0) == 0);
            w = timeout ? int'(MAXW) + 1 : int'($urandom_range(MAXW, 0));
            check_pc(pc_exp, "rnd_pc_fetch");
            for (int i = 0; i < w; i++) cyc(1, rb(), 0, rb(), rb(), rb(), ef(0), "rnd_wait");
            if (timeout) begin
                for (int i = 0; i < int'($urandom_range(3, 1)); i++)
                    cyc(1, rb(), rb(), rb(), rb(), rb(), E_FAULT, "rnd_fault");
                cyc(0, rb(), rb(), rb(), rb(), rb(), E_FAULT, "rnd_fault_rst");
                pc_exp = 8'd0;
                cyc(1, 1, rb(), rb(), rb(), rb(), E_IDLE, "rnd_idle");
                continue;
            end
            cyc(1, rb(), 1, rb(), rb(), rb(), ef(1), "rnd_accept");
            pc_exp = pc_exp + 8'd1;
            kind = int'($urandom_range(3, 0));
            case (kind)
                0:       begin h = 0; j = 0;    c = rb(); end
                1:       begin h = 0; j = 1;    c = 1;    end
                2:       begin h = 0; j = rb(); c = ~j;   end
                default: begin h = 1; j = rb(); c = rb(); end
            endcase
            check_pc(pc_exp, "rnd_pc_decode");
            cyc(1, rb(), rb(), h, j, c, E_DEC, "rnd_decode");
            if (kind == 3) begin
                for (int i = 0; i < int'($urandom_range(2, 0)); i++)
                    cyc(1, 0, rb(), rb(), rb(), rb(), E_HALT, "rnd_halt");
                cyc(1, 1, rb(), rb(), rb(), rb(), E_HALT, "rnd_halt_go");
            end else if (kind == 1) begin
                target = 8'($urandom);
                cyc(1, rb(), rb(), rb(), rb(), rb(), E_JUMP, "rnd_jump");
                pc_exp = target;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
